// File: rtl/cute_fetch_pkg.sv
// Shared types and default sizes for the cute instruction-fetch block.
// Optional prefetch in cute_fetch is enabled by defining CUTE_FETCH_PREFETCH_EN.
package cute_fetch_pkg;

   localparam int AW_DEF        = 6;
   localparam int DW_DEF        = 9;
   localparam int MEM_DEPTH_DEF = 10;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      ISSUE = 3'd2,
      EXEC  = 3'd3,
      FAULT = 3'd4
   } state_t;

endpackage

// File: rtl/cute_fetch_pc.sv
// Program counter for cute_fetch: modulo-MEM_DEPTH increment, branch load with
// range check, and the sticky fault flag raised by an out-of-range branch.
module cute_fetch_pc
   import cute_fetch_pkg::*;
#(
   parameter int AW        = AW_DEF,
   parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
   input  logic          clk,
   input  logic          Resetn,
   input  logic          inc,
   input  logic          load,
   input  logic [AW-1:0] target,
   output logic [AW-1:0] pc,
   output logic [AW-1:0] pc_inc,
   output logic          target_bad,
   output logic          fault
);

   localparam int            AW1     = AW + 1;
   localparam logic [AW-1:0] PC_LAST = AW'(MEM_DEPTH - 1);
   localparam logic [AW:0]   DEPTH   = AW1'(MEM_DEPTH);

   // Wrap at MEM_DEPTH, not at 2**AW.
   assign pc_inc     = (pc == PC_LAST) ? '0 : pc + AW'(1);
   assign target_bad = ({1'b0, target} >= DEPTH);

   always_ff @(posedge clk) begin
      if (!Resetn) begin
         pc    <= '0;
         fault <= 1'b0;
      end else begin
         if (load && !target_bad)
            pc <= target;
         else if (inc)
            pc <= pc_inc;
         if (load && target_bad)
            fault <= 1'b1;
      end
   end

endmodule

// File: rtl/cute_fetch.sv
// Instruction-fetch requester for the cute core: req/ack reads from instruction
// memory, one-cycle Run strobe per word. Define CUTE_FETCH_PREFETCH_EN for a one-entry prefetch.
module cute_fetch
   import cute_fetch_pkg::*;
#(
   parameter int AW        = AW_DEF,
   parameter int DW        = DW_DEF,
   parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
   input  logic          clk,
   input  logic          Resetn,
   input  logic          start,
   input  logic          stop,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] DIN,
   output logic          Run,
   input  logic          done,
   input  logic          jmp,
   input  logic [AW-1:0] jmp_target,
   output logic [AW-1:0] pc,
   output logic          fault
);

   state_t        state, state_nxt;
   logic          exec_done, seq_done, jmp_done;
   logic          fetch_take, fetch_gate;
   logic          pf_req, seq_hit;
   logic [AW-1:0] pc_inc;
   logic          target_bad;

   assign exec_done = (state == EXEC) && done;
   assign jmp_done  = exec_done && jmp;
   assign seq_done  = exec_done && !jmp;

`ifdef CUTE_FETCH_PREFETCH_EN
   logic          pf_valid, pf_drain, pf_ack;
   logic [DW-1:0] pf_buf;

   assign pf_req     = (state == EXEC) && !pf_valid;
   assign pf_ack     = pf_req && mem_ack;
   assign seq_hit    = seq_done && !stop && (pf_valid || pf_ack);
   // Hold off a new FETCH request until a stale prefetch ack has been swallowed.
   assign fetch_gate = !pf_drain;
`else
   assign pf_req     = 1'b0;
   assign seq_hit    = 1'b0;
   assign fetch_gate = 1'b1;
`endif

   assign fetch_take = (state == FETCH) && mem_ack && fetch_gate;

   cute_fetch_pc #(
      .AW        (AW),
      .MEM_DEPTH (MEM_DEPTH)
   ) u_pc (
      .clk        (clk),
      .Resetn     (Resetn),
      .inc        (seq_done),
      .load       (jmp_done),
      .target     (jmp_target),
      .pc         (pc),
      .pc_inc     (pc_inc),
      .target_bad (target_bad),
      .fault      (fault)
   );

   always_ff @(posedge clk) begin
      if (!Resetn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (start) state_nxt = FETCH;
         FETCH: if (fetch_take) state_nxt = ISSUE;
         ISSUE: state_nxt = EXEC;
         EXEC: begin
            if (done) begin
               if (jmp && target_bad)
                  state_nxt = FAULT;
               else if (stop)
                  state_nxt = IDLE;
               else if (seq_hit)
                  state_nxt = ISSUE;
               else
                  state_nxt = FETCH;
            end
         end
         FAULT: state_nxt = FAULT;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_req  = 1'b0;
      mem_addr = pc;
      Run      = 1'b0;
      unique case (state)
         FETCH: mem_req = fetch_gate;
         ISSUE: Run = 1'b1;
         EXEC: begin
            mem_req = pf_req;
            if (pf_req)
               mem_addr = pc_inc;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!Resetn)
         DIN <= '0;
      else if (fetch_take)
         DIN <= mem_rdata;
`ifdef CUTE_FETCH_PREFETCH_EN
      else if (seq_hit)
         DIN <= pf_valid ? pf_buf : mem_rdata;
`endif
   end

`ifdef CUTE_FETCH_PREFETCH_EN
   always_ff @(posedge clk) begin
      if (!Resetn) begin
         pf_valid <= 1'b0;
         pf_drain <= 1'b0;
      end else begin
         if (exec_done)
            pf_valid <= 1'b0;
         else if (pf_ack)
            pf_valid <= 1'b1;
         // A sequential step keeps the same address on the bus, so only other exits must drain.
         if (pf_drain && mem_ack)
            pf_drain <= 1'b0;
         else if (exec_done && pf_req && !mem_ack && !(seq_done && !stop))
            pf_drain <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (pf_ack)
         pf_buf <= mem_rdata;
   end
`endif

endmodule

// File: tb/tb_cute_fetch.sv
// Directed bench for cute_fetch: memory responder, PC/fault model driven from the
// issued done/jmp events, per-cycle compare plus literal expectations.
module tb_cute_fetch;

   localparam int AW        = 6;
   localparam int DW        = 9;
   localparam int MEM_DEPTH = 10;
`ifdef CUTE_FETCH_PREFETCH_EN
   localparam int GAP = 5;
`else
   localparam int GAP = 2;
`endif

   logic          clk = 1'b0;
   logic          Resetn, start, stop, done, jmp;
   logic [AW-1:0] jmp_target;
   logic          mem_req, Run, fault;
   logic [AW-1:0] mem_addr, pc;
   logic [DW-1:0] DIN;
   logic          mem_ack   = 1'b0;
   logic [DW-1:0] mem_rdata = '0;

   always #5 clk = ~clk;

   cute_fetch #(.AW(AW), .DW(DW), .MEM_DEPTH(MEM_DEPTH)) dut (
      .clk        (clk),
      .Resetn     (Resetn),
      .start      (start),
      .stop       (stop),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .DIN        (DIN),
      .Run        (Run),
      .done       (done),
      .jmp        (jmp),
      .jmp_target (jmp_target),
      .pc         (pc),
      .fault      (fault)
   );

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [DW-1:0] mem [0:63];
   int            exp_pc    = 0;
   logic          exp_fault = 1'b0;
   bit            chk_en    = 1'b0;
   bit            resp_en   = 1'b0;
   int            ack_delay = 2;
   int            ack_req_cnt = 0;
   int            ack_done_cnt = 0;
   int            wait_cnt = 0;
   int            cyc = 0;
   int            last_ack_cyc = -10;
   logic          prev_run = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Memory responder: acks ack_delay cycles into a request, or once on demand.
   always @(posedge clk) begin
      #1;
      if (mem_ack)
         mem_ack = 1'b0;
      else if (ack_req_cnt > ack_done_cnt) begin
         mem_ack   = 1'b1;
         mem_rdata = mem[mem_addr];
         ack_done_cnt++;
      end else if (resp_en && mem_req) begin
         if (wait_cnt >= ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
            wait_cnt  = 0;
         end else
            wait_cnt++;
      end else
         wait_cnt = 0;
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      cyc++;
      if (chk_en) begin
         check("pc", 32'(pc), 32'(exp_pc));
         check("fault", 32'(fault), 32'(exp_fault));
         if (exp_fault) begin
            check("fault_quiet_req", 32'(mem_req), 0);
            check("fault_quiet_run", 32'(Run), 0);
         end
         if (Run) begin
            check("din_at_run", 32'(DIN), 32'(mem[exp_pc]));
            check("run_width", 32'(prev_run), 0);
`ifndef CUTE_FETCH_PREFETCH_EN
            check("ack_to_run", cyc, last_ack_cyc + 1);
`endif
         end
         if (mem_req) begin
`ifdef CUTE_FETCH_PREFETCH_EN
            check("req_addr", 32'((int'(mem_addr) == exp_pc) ||
                                  (int'(mem_addr) == (exp_pc + 1) % MEM_DEPTH)), 1);
`else
            check("req_addr", 32'(mem_addr), 32'(exp_pc));
`endif
         end
      end
      if (mem_ack && mem_req) last_ack_cyc = cyc;
      prev_run = Run;
   end

   task automatic do_reset();
      chk_en     = 1'b0;
      Resetn     = 1'b0;
      start      = 1'b0;
      stop       = 1'b0;
      done       = 1'b0;
      jmp        = 1'b0;
      jmp_target = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      Resetn    = 1'b1;
      exp_pc    = 0;
      exp_fault = 1'b0;
      chk_en    = 1'b1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_run(input string name);
      bit found = 1'b0;
      for (int k = 0; k < 60 && !found; k++) begin
         @(posedge clk);
         #1;
         if (Run === 1'b1) found = 1'b1;
      end
      check(name, 32'(found), 1);
   endtask

   // Called at a Run cycle; waits n edges, then presents done for one edge.
   task automatic exec_done(input bit jmp_i, input int tgt, input bit stop_i, input int n);
      repeat (n) @(posedge clk);
      #1;
      done       = 1'b1;
      jmp        = jmp_i;
      jmp_target = AW'(tgt);
      stop       = stop_i;
      @(posedge clk);
      #1;
      done = 1'b0;
      jmp  = 1'b0;
      stop = 1'b0;
      if (jmp_i) begin
         if (tgt >= MEM_DEPTH) exp_fault = 1'b1;
         else exp_pc = tgt;
      end else
         exp_pc = (exp_pc + 1) % MEM_DEPTH;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 9'((i * 37 + 5) % 512);
      mem[0]  = 9'b001000001;
      resp_en = 1'b1;
      do_reset();

      // 1: reset state, first fetch from address 0
      check("rst_pc", 32'(pc), 0);
      check("rst_req", 32'(mem_req), 0);
      check("rst_addr", 32'(mem_addr), 0);
      check("rst_run", 32'(Run), 0);
      check("rst_din", 32'(DIN), 0);
      check("rst_fault", 32'(fault), 0);
      pulse_start();
      check("t1_req", 32'(mem_req), 1);
      check("t1_addr", 32'(mem_addr), 0);
      wait_run("t1_run");
      check("t1_din", 32'(DIN), 32'(9'b001000001));
      check("t1_pc", 32'(pc), 0);

      // 2: sequential run up to pc=9, then wrap to 0
      for (int i = 0; i < 9; i++) begin
         exec_done(1'b0, 0, 1'b0, GAP);
         wait_run("t2_run");
      end
      check("t2_pc9", 32'(pc), 9);
      exec_done(1'b0, 0, 1'b0, GAP);
      check("t2_wrap_pc", 32'(pc), 0);
`ifndef CUTE_FETCH_PREFETCH_EN
      check("t2_wrap_addr", 32'(mem_addr), 0);
`endif
      wait_run("t2_wrap_run");

      // 3: jmp without done ignored, taken jump, done outside EXEC ignored
      @(posedge clk);
      #1;
      jmp = 1'b1;
      jmp_target = AW'(6);
      @(posedge clk);
      #1;
      jmp = 1'b0;
      check("t3_jmp_alone", 32'(pc), 0);
      exec_done(1'b1, 3, 1'b0, 1);
      check("t3_pc", 32'(pc), 3);
      done = 1'b1;
      @(posedge clk);
      #1;
      done = 1'b0;
      wait_run("t3_run");
      check("t3_din", 32'(DIN), 32'(mem[3]));

      // stop returns to IDLE after updating pc; done in IDLE ignored
      exec_done(1'b0, 0, 1'b1, GAP);
      done = 1'b1;
      jmp = 1'b1;
      jmp_target = AW'(2);
      @(posedge clk);
      #1;
      done = 1'b0;
      jmp = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("stop_req", 32'(mem_req), 0);
      check("stop_pc", 32'(pc), 4);
      pulse_start();
      wait_run("stop_restart_run");
      check("stop_restart_din", 32'(DIN), 32'(mem[4]));

      // 4: out-of-range jump faults; nothing more until reset
      exec_done(1'b1, 12, 1'b0, GAP);
      check("t4_fault", 32'(fault), 1);
      check("t4_pc", 32'(pc), 4);
      pulse_start();
      repeat (20) @(posedge clk);
      #1;
      check("t4_req", 32'(mem_req), 0);
      do_reset();
      check("t4_fault_clr", 32'(fault), 0);

      // 5: reset while requesting, ack arrives in IDLE
      resp_en = 1'b0;
      pulse_start();
      check("t5_req_up", 32'(mem_req), 1);
      chk_en = 1'b0;
      @(posedge clk);
      #2;
      Resetn = 1'b0;
      ack_req_cnt++;
      @(posedge clk);
      #2;
      Resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("t5_req", 32'(mem_req), 0);
         check("t5_run", 32'(Run), 0);
         check("t5_din", 32'(DIN), 0);
         check("t5_pc", 32'(pc), 0);
      end
      exp_pc = 0;
      exp_fault = 1'b0;
      chk_en = 1'b1;
      resp_en = 1'b1;
      pulse_start();
      wait_run("t5_restart_run");
      check("t5_restart_din", 32'(DIN), 32'(9'b001000001));

`ifdef CUTE_FETCH_PREFETCH_EN
      // 6: prefetch hit at pc=4, then a taken jump discards the buffer
      for (int i = 0; i < 4; i++) begin
         exec_done(1'b0, 0, 1'b0, GAP);
         wait_run("t6_run");
      end
      check("t6_pc4", 32'(pc), 4);
      exec_done(1'b0, 0, 1'b0, GAP);
      check("t6_hit_run", 32'(Run), 1);
      check("t6_hit_din", 32'(DIN), 32'(mem[5]));
      exec_done(1'b1, 7, 1'b0, GAP);
      check("t6_jmp_req", 32'(mem_req), 1);
      check("t6_jmp_addr", 32'(mem_addr), 7);
      wait_run("t6_jmp_run");
      check("t6_jmp_din", 32'(DIN), 32'(mem[7]));
`endif

      repeat (3) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
